seg_display_sched: RTL and testbench

SEG_DISPLAY_SCHED -- requirements
Module: seg_display_sched

---
 rtl/seg_display_sched.sv | 154 +++++++++++++++
 tb/tb_seg_display_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_sched.sv
// Rotating 3-source scheduler for an 8-digit display: stores requester values and
// shows each loaded source for DWELL cycles. Optional clr[2:0] input via SEG_SCHED_CLEAR_EN.
module seg_display_sched #(
    parameter int unsigned DWELL = 32'd115_000_000,
    parameter int unsigned CW    = 32'd28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  wr_en,
    input  logic [31:0] wr_data0,
    input  logic [31:0] wr_data1,
    input  logic [31:0] wr_data2,
    input  logic        pause,
`ifdef SEG_SCHED_CLEAR_EN
    input  logic [2:0]  clr,
`endif
    output logic [2:0]  wr_ack,
    output logic [31:0] disp_data,
    output logic [1:0]  disp_src,
    output logic        disp_valid,
    output logic        dwell_tick
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHOW = 2'd1, ST_HOLD = 2'd2} state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_r, state_nx;
    logic [31:0]   data_r [3];
    logic [31:0]   data_nx [3];
    logic [31:0]   wr_data_s [3];
    logic [2:0]    loaded_r, loaded_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic [1:0]    src_r, src_nx;
    logic          tick_nx;
    logic [2:0]    clr_s;
    logic          run_s;

`ifdef SEG_SCHED_CLEAR_EN
    assign clr_s = clr;
`else
    assign clr_s = 3'b000;
`endif

    assign wr_data_s[0] = wr_data0;
    assign wr_data_s[1] = wr_data1;
    assign wr_data_s[2] = wr_data2;
    assign run_s        = (state_r != ST_IDLE) && !pause;

    // Next loaded source after src in cyclic order 0->1->2->0; src itself if it is the only one.
    function automatic logic [1:0] next_loaded(input logic [1:0] src, input logic [2:0] mask);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        idx   = src;
        res   = src;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (mask[idx] && !found) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

    function automatic logic [1:0] lowest_set(input logic [2:0] v);
        return v[0] ? 2'd0 : (v[1] ? 2'd1 : 2'd2);
    endfunction

    // Next-state computation: storage, preemption, clear-advance and dwell rotation.
    always_comb begin
        loaded_nx = loaded_r;
        src_nx    = src_r;
        cnt_nx    = cnt_r;
        tick_nx   = 1'b0;
        state_nx  = state_r;
        for (int i = 0; i < 3; i++) begin
            data_nx[i] = data_r[i];
            if (wr_en[i]) begin
                data_nx[i]   = wr_data_s[i];
                loaded_nx[i] = 1'b1;
            end else if (clr_s[i]) begin
                data_nx[i]   = 32'h0;
                loaded_nx[i] = 1'b0;
            end else begin
                data_nx[i]   = data_r[i];
            end
        end
        // Preemption beats everything, including a rotation landing in the same cycle.
        if ((wr_en != 3'b000) && ((state_r == ST_IDLE) || run_s)) begin
            src_nx = lowest_set(wr_en);
            cnt_nx = '0;
        end else if ((state_r != ST_IDLE) && !loaded_nx[src_r]) begin
            src_nx = next_loaded(src_r, loaded_nx);
            cnt_nx = '0;
        end else if (run_s) begin
            if (cnt_r == CNT_LAST) begin
                cnt_nx  = '0;
                tick_nx = 1'b1;
                src_nx  = next_loaded(src_r, loaded_nx);
            end else begin
                cnt_nx  = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_nx = cnt_r;
        end
        if (loaded_nx == 3'b000) begin
            state_nx = ST_IDLE;
            src_nx   = 2'd0;
            cnt_nx   = '0;
        end else if (pause) begin
            state_nx = ST_HOLD;
        end else begin
            state_nx = ST_SHOW;
        end
    end

    // State, storage and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            loaded_r   <= 3'b000;
            cnt_r      <= '0;
            src_r      <= 2'd0;
            wr_ack     <= 3'b000;
            dwell_tick <= 1'b0;
            disp_data  <= 32'h0;
            disp_valid <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                data_r[i] <= 32'h0;
            end
        end else begin
            state_r    <= state_nx;
            loaded_r   <= loaded_nx;
            cnt_r      <= cnt_nx;
            src_r      <= src_nx;
            wr_ack     <= wr_en;
            dwell_tick <= tick_nx;
            disp_data  <= (state_nx == ST_IDLE) ? 32'h0 : data_nx[src_nx];
            disp_valid <= (loaded_nx != 3'b000);
            for (int i = 0; i < 3; i++) begin
                data_r[i] <= data_nx[i];
            end
        end
    end

    assign disp_src = src_r;

endmodule

// File: tb/tb_seg_display_sched.sv
// Self-checking bench for seg_display_sched (DWELL=4): directed vector table,
// reset/one-source corner sequences, and randomized traffic against a reference model.
module tb_seg_display_sched;

    localparam int DW = 4;

    logic        clk;
    logic        rst_n;
    logic [2:0]  wr_en;
    logic [31:0] wr_data0, wr_data1, wr_data2;
    logic        pause;
    logic [2:0]  wr_ack;
    logic [31:0] disp_data;
    logic [1:0]  disp_src;
    logic        disp_valid;
    logic        dwell_tick;
`ifdef SEG_SCHED_CLEAR_EN
    logic [2:0]  clr;
`endif

    int checks = 0;
    int errors = 0;

    seg_display_sched #(.DWELL(32'd4), .CW(32'd4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
        .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_data2(wr_data2),
        .pause(pause),
`ifdef SEG_SCHED_CLEAR_EN
        .clr(clr),
`endif
        .wr_ack(wr_ack), .disp_data(disp_data), .disp_src(disp_src),
        .disp_valid(disp_valid), .dwell_tick(dwell_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  we;
        logic [31:0] d0, d1, d2;
        logic        p;
        logic [1:0]  src;
        logic [31:0] data;
        logic        valid;
        logic [2:0]  ack;
        logic        tick;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    logic [31:0] m_data [3];
    bit          m_loaded [3];
    int          m_src;
    int          m_cnt;
    bit          m_tick;
    logic [2:0]  m_ack;

    function automatic void add(input logic [2:0] we, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic p, input logic [1:0] src,
                                input logic [31:0] data, input logic valid, input logic [2:0] ack,
                                input logic tick);
        vec_t v;
        v.we = we; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.p = p;
        v.src = src; v.data = data; v.valid = valid; v.ack = ack; v.tick = tick;
        vecs.push_back(v);
    endfunction

    function automatic void idle(input int n, input logic p, input logic [1:0] src, input logic [31:0] data);
        for (int k = 0; k < n; k++) add(3'b000, 32'h0, 32'h0, 32'h0, p, src, data, 1'b1, 3'b000, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] src, input logic [31:0] data,
                           input logic valid, input logic [2:0] ack, input logic tick);
        chk({tag, "_src"},   {30'h0, disp_src},   {30'h0, src});
        chk({tag, "_data"},  disp_data,           data);
        chk({tag, "_valid"}, {31'h0, disp_valid}, {31'h0, valid});
        chk({tag, "_ack"},   {29'h0, wr_ack},     {29'h0, ack});
        chk({tag, "_tick"},  {31'h0, dwell_tick}, {31'h0, tick});
    endtask

    task automatic apply(input logic [2:0] we, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic p);
        wr_en = we; wr_data0 = d0; wr_data1 = d1; wr_data2 = d2; pause = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 3'b000; pause = 1'b0;
        wr_data0 = 32'h0; wr_data1 = 32'h0; wr_data2 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin m_data[i] = 32'h0; m_loaded[i] = 1'b0; end
        m_src = 0; m_cnt = 0; m_tick = 1'b0; m_ack = 3'b000;
    endtask

    // Behavioural model: one clock edge of the scheduler's rules.
    task automatic model_step(input logic [2:0] we, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic p);
        bit any_before;
        bit running;
        any_before = m_loaded[0] || m_loaded[1] || m_loaded[2];
        running    = any_before && !p;
        if (we[0]) begin m_data[0] = d0; m_loaded[0] = 1'b1; end
        if (we[1]) begin m_data[1] = d1; m_loaded[1] = 1'b1; end
        if (we[2]) begin m_data[2] = d2; m_loaded[2] = 1'b1; end
        m_tick = 1'b0;
        m_ack  = we;
        if (we != 3'b000 && (!any_before || running)) begin
            m_src = we[0] ? 0 : (we[1] ? 1 : 2);
            m_cnt = 0;
        end else if (running) begin
            if (m_cnt == DW - 1) begin
                m_cnt  = 0;
                m_tick = 1'b1;
                for (int k = 1; k <= 3; k++) begin
                    if (m_loaded[(m_src + k) % 3]) begin
                        m_src = (m_src + k) % 3;
                        break;
                    end
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    initial begin
        logic p;
        logic [2:0] we;
        logic [31:0] d0, d1, d2;
        bit any;
`ifdef SEG_SCHED_CLEAR_EN
        clr = 3'b000;
`endif
        // directed table
        add(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'b000, 1'b0);
        add(3'b010, 32'h0, 32'h1234_5678, 32'h0, 1'b0, 2'd1, 32'h1234_5678, 1'b1, 3'b010, 1'b0);
        add(3'b101, 32'hA0A0_A0A0, 32'h0, 32'hC2C2_C2C2, 1'b0, 2'd0, 32'hA0A0_A0A0, 1'b1, 3'b101, 1'b0);
        idle(3, 1'b0, 2'd0, 32'hA0A0_A0A0);
        add(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1, 32'h1234_5678, 1'b1, 3'b000, 1'b1);
        idle(3, 1'b0, 2'd1, 32'h1234_5678);
        add(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 32'hC2C2_C2C2, 1'b1, 3'b000, 1'b1);
        idle(3, 1'b0, 2'd2, 32'hC2C2_C2C2);
        add(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 32'hA0A0_A0A0, 1'b1, 3'b000, 1'b1);
        idle(3, 1'b0, 2'd0, 32'hA0A0_A0A0);
        // simultaneous writes landing on the rotation cycle
        add(3'b110, 32'h0, 32'h1111_1111, 32'h2222_2222, 1'b0, 2'd1, 32'h1111_1111, 1'b1, 3'b110, 1'b0);
        idle(3, 1'b0, 2'd1, 32'h1111_1111);
        add(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 32'h2222_2222, 1'b1, 3'b000, 1'b1);
        idle(1, 1'b0, 2'd2, 32'h2222_2222);
        // pause for 10 cycles with writes to sources 2 and 0
        idle(2, 1'b1, 2'd2, 32'h2222_2222);
        add(3'b100, 32'h0, 32'h0, 32'h3333_3333, 1'b1, 2'd2, 32'h3333_3333, 1'b1, 3'b100, 1'b0);
        idle(1, 1'b1, 2'd2, 32'h3333_3333);
        add(3'b001, 32'h4444_4444, 32'h0, 32'h0, 1'b1, 2'd2, 32'h3333_3333, 1'b1, 3'b001, 1'b0);
        idle(5, 1'b1, 2'd2, 32'h3333_3333);
        idle(2, 1'b0, 2'd2, 32'h3333_3333);
        add(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h4444_4444, 1'b1, 3'b000, 1'b1);

        do_reset();
        chk_all("reset", 2'd0, 32'h0, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].we, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].p);
            chk_all($sformatf("vec%0d", i), vecs[i].src, vecs[i].data, vecs[i].valid, vecs[i].ack, vecs[i].tick);
        end

        // asynchronous reset mid-operation drops the in-flight ack
        apply(3'b010, 32'h0, 32'h5555_5555, 32'h0, 1'b0);
        chk_all("pre_rst", 2'd1, 32'h5555_5555, 1'b1, 3'b010, 1'b0);
        wr_en = 3'b000;
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 2'd0, 32'h0, 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // single loaded source: rotation keeps src but still ticks
        apply(3'b100, 32'h0, 32'h0, 32'h6666_6666, 1'b0);
        chk_all("post_rst_wr", 2'd2, 32'h6666_6666, 1'b1, 3'b100, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
            chk_all("one_src", 2'd2, 32'h6666_6666, 1'b1, 3'b000, 1'b0);
        end
        apply(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
        chk_all("one_src_tick", 2'd2, 32'h6666_6666, 1'b1, 3'b000, 1'b1);

`ifdef SEG_SCHED_CLEAR_EN
        do_reset();
        apply(3'b011, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0, 1'b0);
        chk_all("clr_load", 2'd0, 32'h0A0A_0A0A, 1'b1, 3'b011, 1'b0);
        clr = 3'b001;
        apply(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
        chk_all("clr_adv", 2'd1, 32'h0B0B_0B0B, 1'b1, 3'b000, 1'b0);
        clr = 3'b010;
        apply(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
        chk_all("clr_all", 2'd0, 32'h0, 1'b0, 3'b000, 1'b0);
        clr = 3'b000;
`endif

        // randomized traffic against the model
        do_reset();
        p = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            we = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if ($urandom_range(0, 24) == 0) p = !p;
            d0 = $urandom; d1 = $urandom; d2 = $urandom;
            apply(we, d0, d1, d2, p);
            model_step(we, d0, d1, d2, p);
            any = m_loaded[0] || m_loaded[1] || m_loaded[2];
            chk_all("rnd", 2'(m_src), any ? m_data[m_src] : 32'h0, any, m_ack, m_tick);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
